rl_ram_1rw_gen: RTL and testbench

Generic, technology-independent single-port (1RW) synchronous RAM of 2^ABITS words x DBITS bits with per-byte write enables. It is the inferrable fallback used under the rl_ram_1rw technology wrapper whenever no vendor macro is selected. It is written so that FPGA and ASIC synthesis tools infer block RAM.

---
 rtl/rl_ram_pkg.sv | 36 +++
 rtl/rl_ram_1rw_be_merge.sv | 29 ++
 rtl/rl_ram_1rw_gen.sv | 95 +++++++++
 tb/tb_rl_ram_1rw_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rl_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rl_ram_pkg
// Brief   : Shared helpers for the rl_ram family: byte-lane count and the
//           expansion of per-byte enables into a per-bit write mask.
// Revision: 1.0 - initial release
// ============================================================================
package rl_ram_pkg;

    // Widest data word the lane-mask helper supports.
    localparam int MAX_DBITS = 256;
    localparam int MAX_NBE   = MAX_DBITS / 8;

    // Number of byte lanes for a word of dbits bits; the top lane may be partial.
    function automatic int lane_count(input int dbits);
        return (dbits + 7) / 8;
    endfunction

    // Expand byte enables into a bit mask. Bits at or above dbits stay zero,
    // so a partial top lane only covers the bits that actually exist.
    function automatic logic [MAX_DBITS-1:0] lane_mask(
        input logic [MAX_NBE-1:0] be,
        input int                 dbits
    );
        logic [MAX_DBITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_DBITS; i++) begin
            if (i < dbits) begin
                mask[i] = be[i / 8];
            end
        end
        return mask;
    endfunction

endpackage : rl_ram_pkg
`default_nettype wire

// File: rtl/rl_ram_1rw_be_merge.sv
`default_nettype none
// ============================================================================
// Module  : rl_ram_1rw_be_merge
// Brief   : Combinational byte-lane merge. Lanes with an enable set take the
//           new data, the rest keep the old word. The result feeds both the
//           array write port and the write-first read bypass.
// Revision: 1.0 - initial release
// ============================================================================
module rl_ram_1rw_be_merge
    import rl_ram_pkg::*;
#(
    parameter int DBITS = 32,
    parameter int NBE   = (DBITS + 7) / 8
) (
    input  logic [DBITS-1:0] old_i,
    input  logic [DBITS-1:0] din_i,
    input  logic [NBE-1:0]   be_i,
    output logic [DBITS-1:0] merged_o
);

    logic [MAX_NBE-1:0] be_ext_w;
    logic [DBITS-1:0]   mask_w;

    assign be_ext_w = MAX_NBE'(be_i);
    assign mask_w   = DBITS'(lane_mask(be_ext_w, DBITS));
    assign merged_o = (din_i & mask_w) | (old_i & ~mask_w);

endmodule : rl_ram_1rw_be_merge
`default_nettype wire

// File: rtl/rl_ram_1rw_gen.sv
`default_nettype none
// ============================================================================
// Module  : rl_ram_1rw_gen
// Brief   : Generic single-port synchronous RAM, 2^ABITS x DBITS, per-byte
//           write enables, write-first read-during-write, 1-cycle read latency.
//           Optional macro RL_RAM_1RW_DOUT_REG_EN adds an output pipeline
//           register (read latency 2).
// Revision: 1.0 - initial release
// ============================================================================
module rl_ram_1rw_gen
    import rl_ram_pkg::*;
#(
    parameter int    ABITS     = 10,
    parameter int    DBITS     = 32,
    parameter string INIT_FILE = ""
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ABITS-1:0]           addr_i,
    input  logic                       we_i,
    input  logic [(DBITS+7)/8-1:0]     be_i,
    input  logic [DBITS-1:0]           din_i,
    output logic [DBITS-1:0]           dout_o
);

    localparam int NBE   = lane_count(DBITS);
    localparam int DEPTH = 1 << ABITS;

    // Elaboration-time sanity checks on the configuration.
    if (ABITS < 1 || DBITS < 1) begin : g_bad_size
        $error("rl_ram_1rw_gen: ABITS and DBITS must both be >= 1");
    end
    if (DBITS > MAX_DBITS) begin : g_too_wide
        $error("rl_ram_1rw_gen: DBITS exceeds rl_ram_pkg::MAX_DBITS");
    end

    logic [DBITS-1:0] mem_q [0:DEPTH-1];
    logic [DBITS-1:0] old_w;
    logic [NBE-1:0]   wr_be_w;
    logic [DBITS-1:0] merged_w;
    logic [DBITS-1:0] dout_d;
    logic [DBITS-1:0] dout_q;

    // A read cycle is a merge with no lanes enabled, so the same path yields
    // plain read data, the write-first word and the value to store.
    assign old_w   = mem_q[addr_i];
    assign wr_be_w = we_i ? be_i : '0;

    rl_ram_1rw_be_merge #(
        .DBITS (DBITS),
        .NBE   (NBE)
    ) u_be_merge (
        .old_i    (old_w),
        .din_i    (din_i),
        .be_i     (wr_be_w),
        .merged_o (merged_w)
    );

    assign dout_d = merged_w;

    // Array write port; reset suppresses writes but never clears contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && we_i) begin
            mem_q[addr_i] <= merged_w;
        end
    end

    // Read data register: captures the (write-first) word of the addressed location.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

`ifdef RL_RAM_1RW_DOUT_REG_EN
    logic [DBITS-1:0] dout_pipe_q;

    // Extra output stage for timing closure; cleared together with dout_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_pipe_q <= '0;
        end else begin
            dout_pipe_q <= dout_q;
        end
    end

    assign dout_o = dout_pipe_q;
`else
    assign dout_o = dout_q;
`endif

endmodule : rl_ram_1rw_gen
`default_nettype wire

// File: tb/tb_rl_ram_1rw_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_rl_ram_1rw_gen
// Brief   : Directed self-checking bench for rl_ram_1rw_gen (32-bit and
//           12-bit partial-lane instances). Honours RL_RAM_1RW_DOUT_REG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rl_ram_1rw_gen;

`ifdef RL_RAM_1RW_DOUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [9:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] dout;

    logic [9:0]  addr_b;
    logic        we_b;
    logic [1:0]  be_b;
    logic [11:0] din_b;
    logic [11:0] dout_b;

    int checks = 0;
    int errors = 0;

    rl_ram_1rw_gen #(.ABITS(10), .DBITS(32), .INIT_FILE("")) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .addr_i (addr),
        .we_i   (we),
        .be_i   (be),
        .din_i  (din),
        .dout_o (dout)
    );

    rl_ram_1rw_gen #(.ABITS(10), .DBITS(12), .INIT_FILE("")) u_dut12 (
        .clk_i  (clk),
        .rst_i  (rst),
        .addr_i (addr_b),
        .we_i   (we_b),
        .be_i   (be_b),
        .din_i  (din_b),
        .dout_o (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [9:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d);
        addr = a;
        we   = w;
        be   = b;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    // With the output pipeline enabled, one harmless read of the same address
    // lets the previous result reach dout.
    task automatic settle();
        if (LAT == 2) step(addr, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Back-to-back stimulus and the value each access must return.
    logic [9:0]  b2b_a [0:9];
    logic        b2b_w [0:9];
    logic [3:0]  b2b_b [0:9];
    logic [31:0] b2b_d [0:9];
    logic [31:0] b2b_e [0:9];

    initial begin
        rst = 1'b1; addr = '0; we = 1'b0; be = '0; din = '0;
        addr_b = '0; we_b = 1'b0; be_b = '0; din_b = '0;
        @(posedge clk);
        #1;

        // Reset with a pending write: output stays zero, write is dropped.
        step(10'h005, 1'b1, 4'hF, 32'hDEADBEEF);
        chk("reset_cycle0", dout, 32'h0);
        step(10'h005, 1'b1, 4'hF, 32'hDEADBEEF);
        chk("reset_cycle1", dout, 32'h0);
        rst = 1'b0;
        step(10'h005, 1'b0, 4'h0, 32'h0);
        settle();
        checks++;
        assert (dout !== 32'hDEADBEEF) else begin
            errors++;
            $error("FAIL reset_write_dropped: observed %h expected not DEADBEEF", dout);
        end

        // Full-word write then read at the top address.
        step(10'h3FF, 1'b1, 4'hF, 32'h12345678);
        settle();
        chk("full_wf", dout, 32'h12345678);
        step(10'h3FF, 1'b0, 4'h0, 32'h0);
        settle();
        chk("full_rd", dout, 32'h12345678);

        // Byte enables merge into the existing word.
        step(10'h010, 1'b1, 4'hF, 32'hAABBCCDD);
        settle();
        chk("be_full_wf", dout, 32'hAABBCCDD);
        step(10'h010, 1'b1, 4'h5, 32'h11223344);
        settle();
        chk("be_part_wf", dout, 32'hAA22CC44);
        step(10'h010, 1'b0, 4'h0, 32'h0);
        settle();
        chk("be_part_rd", dout, 32'hAA22CC44);

        // Write with no lanes enabled changes nothing.
        step(10'h010, 1'b1, 4'h0, 32'hFFFFFFFF);
        settle();
        chk("noop_wf", dout, 32'hAA22CC44);
        step(10'h010, 1'b0, 4'h0, 32'h0);
        settle();
        chk("noop_rd", dout, 32'hAA22CC44);

        // Access coinciding with reset is dropped; the next one is normal.
        rst = 1'b1;
        step(10'h010, 1'b1, 4'hF, 32'h00000000);
        chk("midreset_dout", dout, 32'h0);
        rst = 1'b0;
        step(10'h010, 1'b0, 4'h0, 32'h0);
        settle();
        chk("midreset_rd", dout, 32'hAA22CC44);

        // Back-to-back alternating addresses, checked every cycle at exact latency.
        b2b_a[0] = 10'h000; b2b_w[0] = 1'b1; b2b_b[0] = 4'hF; b2b_d[0] = 32'h00000001; b2b_e[0] = 32'h00000001;
        b2b_a[1] = 10'h3FF; b2b_w[1] = 1'b0; b2b_b[1] = 4'h0; b2b_d[1] = 32'h0;        b2b_e[1] = 32'h12345678;
        b2b_a[2] = 10'h000; b2b_w[2] = 1'b0; b2b_b[2] = 4'h0; b2b_d[2] = 32'h0;        b2b_e[2] = 32'h00000001;
        b2b_a[3] = 10'h3FF; b2b_w[3] = 1'b1; b2b_b[3] = 4'hF; b2b_d[3] = 32'hCAFEF00D; b2b_e[3] = 32'hCAFEF00D;
        b2b_a[4] = 10'h000; b2b_w[4] = 1'b0; b2b_b[4] = 4'h0; b2b_d[4] = 32'h0;        b2b_e[4] = 32'h00000001;
        b2b_a[5] = 10'h3FF; b2b_w[5] = 1'b0; b2b_b[5] = 4'h0; b2b_d[5] = 32'h0;        b2b_e[5] = 32'hCAFEF00D;
        b2b_a[6] = 10'h000; b2b_w[6] = 1'b1; b2b_b[6] = 4'h1; b2b_d[6] = 32'hFFFFFF02; b2b_e[6] = 32'h00000002;
        b2b_a[7] = 10'h3FF; b2b_w[7] = 1'b1; b2b_b[7] = 4'h8; b2b_d[7] = 32'h5A000000; b2b_e[7] = 32'h5AFEF00D;
        b2b_a[8] = 10'h000; b2b_w[8] = 1'b0; b2b_b[8] = 4'h0; b2b_d[8] = 32'h0;        b2b_e[8] = 32'h00000002;
        b2b_a[9] = 10'h3FF; b2b_w[9] = 1'b0; b2b_b[9] = 4'h0; b2b_d[9] = 32'h0;        b2b_e[9] = 32'h5AFEF00D;
        for (int s = 0; s < 10 + LAT - 1; s++) begin
            if (s < 10) step(b2b_a[s], b2b_w[s], b2b_b[s], b2b_d[s]);
            else        step(10'h000, 1'b0, 4'h0, 32'h0);
            if (s >= LAT - 1) chk($sformatf("b2b_%0d", s - (LAT - 1)), dout, b2b_e[s - (LAT - 1)]);
        end

        // Partial top lane on the 12-bit instance: be_b[1] covers bits [11:8].
        we = 1'b0;
        addr_b = 10'h003; we_b = 1'b1; be_b = 2'b11; din_b = 12'hFFF;
        @(posedge clk); #1;
        be_b = 2'b10; din_b = 12'h000;
        @(posedge clk); #1;
        we_b = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
        chk("partial_hi", {20'h0, dout_b}, 32'h000000FF);
        we_b = 1'b1; be_b = 2'b01; din_b = 12'hA5A;
        @(posedge clk); #1;
        we_b = 1'b0;
        repeat (LAT) begin @(posedge clk); #1; end
        chk("partial_lo", {20'h0, dout_b}, 32'h0000005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100us");
        $fatal(1, "timeout");
    end

endmodule : tb_rl_ram_1rw_gen
`default_nettype wire
